// File: rtl/rs232_pkg.sv
// Constants and state encoding shared by the RS-232 transmitter (nadajnik) and receiver (odbiornik).
// Both sides of the link decode the same frame format from these definitions.
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rs232_state_t;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam int   DATA_BITS   = 8;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/nadajnik_dzielnik_baud.sv
// Bit-rate clock-enable divider: tick is high for one cycle every DIV cycles.
// clear forces the count to zero so a new frame starts phase-aligned.
module dzielnik_baud #(
  parameter int DIV = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  output logic tick
);

  localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/nadajnik.sv
// RS-232 transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Optional feature: define PARITY_EN to insert the parity bit (frame grows from 10*DIV to 11*DIV cycles).
// Handshake: a byte is taken on a rising edge where valid_i & ready_o; ready_o is high only in IDLE.
module nadajnik
  import rs232_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       TXD_o,
  output logic       busy_o,
  output logic [2:0] state_o
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  rs232_state_t   r_state;
  rs232_state_t   w_state_next;
  logic [7:0]     r_shift;
  logic [7:0]     w_shift_next;
  logic [2:0]     r_bitcnt;
  logic [2:0]     w_bitcnt_next;
  logic           r_txd;
  logic           w_txd_next;
  logic           w_accept;
  logic           w_tick;
  logic           w_div_clear;
`ifdef PARITY_EN
  logic           r_parity;
  logic           w_parity_next;
`endif

  assign w_accept    = valid_i & (r_state == IDLE);
  // Holding the divider clear while idle aligns bit timing to the acceptance edge.
  assign w_div_clear = (r_state == IDLE);

  dzielnik_baud #(
    .DIV (DIV)
  ) u_dzielnik_baud (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clear (w_div_clear),
    .tick  (w_tick)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_txd    <= LINE_IDLE;
`ifdef PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_shift  <= w_shift_next;
      r_bitcnt <= w_bitcnt_next;
      r_txd    <= w_txd_next;
`ifdef PARITY_EN
      r_parity <= w_parity_next;
`endif
    end
  end

  // The line level is computed for the state being entered so TXD_o stays a plain flop output.
  always_comb begin
    w_state_next  = r_state;
    w_shift_next  = r_shift;
    w_bitcnt_next = r_bitcnt;
    w_txd_next    = r_txd;
`ifdef PARITY_EN
    w_parity_next = r_parity;
`endif
    case (r_state)
      IDLE: begin
        w_txd_next = LINE_IDLE;
        if (w_accept) begin
          w_state_next  = START;
          w_shift_next  = data_i;
          w_bitcnt_next = '0;
          w_txd_next    = START_LEVEL;
`ifdef PARITY_EN
          w_parity_next = even_parity(data_i);
`endif
        end
      end
      START: begin
        if (w_tick) begin
          w_state_next = DATA;
          w_txd_next   = r_shift[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_next  = r_shift >> 1;
          w_bitcnt_next = r_bitcnt + 3'd1;
          if (r_bitcnt == LAST_BIT) begin
`ifdef PARITY_EN
            w_state_next = PARITY;
            w_txd_next   = r_parity;
`else
            w_state_next = STOP;
            w_txd_next   = LINE_IDLE;
`endif
          end else begin
            w_txd_next = r_shift[1];
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (w_tick) begin
          w_state_next = STOP;
          w_txd_next   = LINE_IDLE;
        end
      end
`endif
      STOP: begin
        if (w_tick) begin
          w_state_next = IDLE;
          w_txd_next   = LINE_IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_txd_next   = LINE_IDLE;
      end
    endcase
  end

  assign ready_o = (r_state == IDLE);
  assign busy_o  = (r_state != IDLE);
  assign TXD_o   = r_txd;
  assign state_o = r_state;

endmodule

// File: tb/tb_nadajnik.sv
// Self-checking bench for nadajnik: expected line levels are queued per accepted byte
// and compared cycle by cycle against TXD_o. Honours PARITY_EN like the design.
module tb_nadajnik;

  localparam int DIV = 10;
`ifdef PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * DIV;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       TXD_o;
  logic       busy_o;
  logic [2:0] state_o;

  logic [0:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  nadajnik #(.DIV(DIV)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .TXD_o   (TXD_o),
    .busy_o  (busy_o),
    .state_o (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  // driver tasks
  task automatic push_frame(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef PARITY_EN
    exp_q.push_back(^b);
`endif
    exp_q.push_back(1'b1);
  endtask

  task automatic accept(input logic [7:0] b, input logic keep_valid);
    int waited;
    waited = 0;
    @(negedge clk);
    data_i  = b;
    valid_i = 1'b1;
    while (ready_o !== 1'b1 && waited < 3 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (ready_o === 1'b1) n_pass++;
    else $display("FAIL accept_ready: ready_o=%b required 1 (timeout)", ready_o);
    push_frame(b);
    @(posedge clk);
    #1;
    if (!keep_valid) begin
      valid_i = 1'b0;
      data_i  = 8'($urandom_range(0, 255));
    end
  endtask

  // scoreboard: pops one expected level per bit period and checks every cycle of it
  task automatic check_frame(input logic disturb);
    logic exp_bit;
    for (int k = 0; k < FRAME_BITS; k++) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL queue_empty: bit %0d has no expected value, required queued value", k);
        exp_bit = 1'b1;
      end else begin
        exp_bit = exp_q.pop_front();
      end
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk);
        n_checks++;
        if (TXD_o === exp_bit) n_pass++;
        else $display("FAIL txd_bit%0d_cyc%0d: TXD_o=%b required %b", k, c, TXD_o, exp_bit);
        if (c == 0) begin
          n_checks++;
          if (busy_o === 1'b1 && ready_o === 1'b0) n_pass++;
          else $display("FAIL busy_bit%0d: busy_o=%b ready_o=%b required 1/0", k, busy_o, ready_o);
        end
        if (disturb) begin
          if (k == 3 && c == 2) begin
            data_i  = ~data_i;
            valid_i = 1'b1;
          end
          if (k == 5 && c == 0) valid_i = 1'b0;
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (ready_o === 1'b1 && busy_o === 1'b0 && TXD_o === 1'b1) n_pass++;
    else $display("FAIL idle_after_frame: ready_o=%b busy_o=%b TXD_o=%b required 1/0/1",
                  ready_o, busy_o, TXD_o);
  endtask

  task automatic check_quiet(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      n_checks++;
      if (TXD_o === 1'b1 && busy_o === 1'b0 && ready_o === 1'b1) n_pass++;
      else $display("FAIL %s_cyc%0d: TXD_o=%b busy_o=%b ready_o=%b required 1/0/1",
                    name, i, TXD_o, busy_o, ready_o);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_i   = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'hA5;
    check_quiet(5, "reset_hold");
    n_checks++;
    if (state_o === 3'd0) n_pass++;
    else $display("FAIL reset_state: state_o=%0d required 0", state_o);
    valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    check_quiet(2 * DIV, "after_reset");
  endtask

  task automatic test_frame_a5();
    accept(8'hA5, 1'b0);
    check_frame(1'b0);
  endtask

  task automatic test_patterns();
    logic [7:0] b;
    accept(8'h01, 1'b0);
    check_frame(1'b0);
    accept(8'h80, 1'b0);
    check_frame(1'b0);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      accept(b, 1'b0);
      check_frame(1'b0);
    end
  endtask

  task automatic test_back_to_back();
    accept(8'h00, 1'b1);
    data_i = 8'hFF;
    check_frame(1'b0);
    // valid_i still high: the idle cycle just checked is the acceptance cycle for 8'hFF
    push_frame(8'hFF);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    check_frame(1'b0);
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    accept(8'h07, 1'b0);
    check_frame(1'b0);
    accept(8'h03, 1'b0);
    check_frame(1'b0);
  endtask
`endif

  task automatic test_ignore_busy();
    accept(8'h3C, 1'b0);
    check_frame(1'b1);
    check_quiet(2 * DIV, "no_queued_frame");
  endtask

  task automatic test_reset_mid();
    accept(8'hF0, 1'b0);
    exp_q.delete();
    repeat (4 * DIV + 5) @(negedge clk);
    n_checks++;
    if (TXD_o === 1'b0) n_pass++;
    else $display("FAIL mid_bit4_level: TXD_o=%b required 0", TXD_o);
    #2;
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (TXD_o === 1'b1 && ready_o === 1'b1 && busy_o === 1'b0) n_pass++;
    else $display("FAIL async_reset: TXD_o=%b ready_o=%b busy_o=%b required 1/1/0",
                  TXD_o, ready_o, busy_o);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    check_quiet(DIV, "after_mid_reset");
    accept(8'h55, 1'b0);
    check_frame(1'b0);
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_patterns();
    test_back_to_back();
`ifdef PARITY_EN
    test_parity();
`endif
    test_ignore_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
